// File: rtl/pagerank_gather.sv
// Gather stage of the PageRank pipeline: accumulates per-node contributions from scatter,
// then applies new = (1-d)/N + d*sum to every node, one node per cycle, and publishes the
// updated rank vector plus the largest per-node change of the pass.
module pagerank_gather #(
  parameter int unsigned NODES_IN_GRAPH = 32,
  parameter int unsigned FRAC_BITS      = 32,
  parameter int unsigned DAMPING        = 55706
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             gather_enable,
  input  logic                             contrib_valid,
  input  logic [63:0]                      contrib_value,
  input  logic [31:0]                      contrib_node_id,
  input  logic                             scatter_complete,
  input  logic                             start_iteration,
  output logic [NODES_IN_GRAPH-1:0][63:0]  page_rank_new,
  output logic                             update_valid,
  output logic [31:0]                      update_node_id,
  output logic [63:0]                      update_value,
  output logic                             iteration_done,
  output logic [63:0]                      max_delta,
  output logic                             id_error
);

  localparam int unsigned KW = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NODES_IN_GRAPH - 1);
  localparam logic [63:0] INIT_RANK = (64'd1 << FRAC_BITS) / 64'(NODES_IN_GRAPH);
  localparam logic [63:0] BASE_TERM =
      ((64'(65536 - DAMPING) << FRAC_BITS) >> 16) / 64'(NODES_IN_GRAPH);

  typedef enum logic [1:0] {StIdle, StAccum, StApply, StDone} state_e;

  state_e                          state_q;
  logic [KW-1:0]                   k_q;
  logic [63:0]                     acc_q [NODES_IN_GRAPH];
  logic [NODES_IN_GRAPH-1:0][63:0] rank_q;
  logic [63:0]                     run_max_q;
  logic                            update_valid_q;
  logic [31:0]                     update_node_id_q;
  logic [63:0]                     update_value_q;
  logic                            iteration_done_q;
  logic [63:0]                     max_delta_q;
  logic                            id_error_q;

  logic          id_ok;
  logic [KW-1:0] cid;
  logic [64:0]   acc_sum;
  logic [63:0]   acc_sat;
  logic [79:0]   prod;
  logic [64:0]   new_sum;
  logic [63:0]   new_rank;
  logic [63:0]   old_rank;
  logic [63:0]   delta;
  logic [63:0]   run_max_next;

  assign id_ok = contrib_node_id < 32'(NODES_IN_GRAPH);
  assign cid   = contrib_node_id[KW-1:0];

  // Saturating accumulate of the incoming contribution and damping math for node k.
  always_comb begin
    acc_sum      = {1'b0, acc_q[cid]} + {1'b0, contrib_value};
    acc_sat      = acc_sum[64] ? '1 : acc_sum[63:0];
    prod         = {16'd0, acc_q[k_q]} * 80'(DAMPING);
    new_sum      = {1'b0, BASE_TERM} + {1'b0, 64'(prod >> 16)};
    new_rank     = new_sum[64] ? '1 : new_sum[63:0];
    old_rank     = rank_q[k_q];
    delta        = (new_rank >= old_rank) ? (new_rank - old_rank) : (old_rank - new_rank);
    run_max_next = (delta > run_max_q) ? delta : run_max_q;
  end

  // FSM with all datapath state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      k_q              <= '0;
      for (int i = 0; i < int'(NODES_IN_GRAPH); i++) begin
        acc_q[i]  <= '0;
        rank_q[i] <= INIT_RANK;
      end
      run_max_q        <= '0;
      update_valid_q   <= 1'b0;
      update_node_id_q <= '0;
      update_value_q   <= '0;
      iteration_done_q <= 1'b0;
      max_delta_q      <= '0;
      id_error_q       <= 1'b0;
    end else if (!gather_enable) begin
      // Everything holds, but the write strobe is a per-write pulse and must not stretch.
      update_valid_q <= 1'b0;
    end else begin
      update_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q <= StAccum;
        end
        StAccum: begin
          if (contrib_valid) begin
            if (id_ok) begin
              acc_q[cid] <= acc_sat;
            end else begin
              id_error_q <= 1'b1;
            end
          end
          if (scatter_complete) begin
            state_q <= StApply;
          end
        end
        StApply: begin
          rank_q[k_q]      <= new_rank;
          update_valid_q   <= 1'b1;
          update_node_id_q <= 32'(k_q);
          update_value_q   <= new_rank;
          run_max_q        <= run_max_next;
          if (k_q == LAST_K) begin
            state_q     <= StDone;
            max_delta_q <= run_max_next;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (start_iteration) begin
            for (int i = 0; i < int'(NODES_IN_GRAPH); i++) begin
              acc_q[i] <= '0;
            end
            run_max_q        <= '0;
            k_q              <= '0;
            iteration_done_q <= 1'b0;
            state_q          <= StAccum;
          end else begin
            // Registered so it rises the cycle after the last strobe.
            iteration_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign page_rank_new  = rank_q;
  assign update_valid   = update_valid_q;
  assign update_node_id = update_node_id_q;
  assign update_value   = update_value_q;
  assign iteration_done = iteration_done_q;
  assign max_delta      = max_delta_q;
  assign id_error       = id_error_q;

endmodule

// File: doc/pagerank_gather.md
# pagerank_gather

Gather stage of the PageRank pipeline. It consumes the per-edge contribution stream from the scatter stage (`rank/outdegree` tagged with a destination node id) and accumulates contributions per node. When scatter signals completion, it applies the damping formula `new = (1-d)/N + d*sum` to every node, one node per cycle. It then publishes the updated rank vector and a convergence metric for the next iteration.

## Interface
Parameters:
- `NODES_IN_GRAPH`, default 32: number of nodes; size of the accumulator and rank arrays.
- `FRAC_BITS`, default 32: fractional bits of the unsigned 64-bit fixed-point rank format.
- `DAMPING`, default 55706: damping factor d in Q0.16 (55706 ≈ 0.85).

Derived constants (elaboration time):
- `INIT_RANK = (1<<FRAC_BITS)/NODES_IN_GRAPH`
- `BASE_TERM = (((65536-DAMPING)<<FRAC_BITS)>>16)/NODES_IN_GRAPH`

Ports (reset reset_n, asynchronous, active-low; clock clock):
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `gather_enable`  in  1  when low, FSM and all registers hold; contributions are ignored.
- `contrib_valid`  in  1  contribution present this cycle (scatter `output_ready`).
- `contrib_value`  in  64  contribution, fixed-point.
- `contrib_node_id`  in  32  destination node of the contribution.
- `scatter_complete`  in  1  scatter finished the current iteration (scatter `operation_complete`).
- `start_iteration`  in  1  begin the next iteration (drives scatter `nextIteration`).
- `page_rank_new`  out  64 x NODES_IN_GRAPH  current rank vector (feeds scatter `page_rank_old`).
- `update_valid`  out  1  one-cycle strobe per node written during APPLY.
- `update_node_id`  out  32  node written this cycle.
- `update_value`  out  64  value written this cycle.
- `iteration_done`  out  1  level; high while in DONE.
- `max_delta`  out  64  max |new-old| over the last APPLY pass.
- `id_error`  out  1  sticky; a contribution arrived with id ≥ NODES_IN_GRAPH.

## Operation
- States: IDLE, ACCUM, APPLY, DONE.
  - IDLE → ACCUM when `gather_enable` is high.
  - ACCUM → APPLY when `scatter_complete` is high.
  - APPLY → DONE after node NODES_IN_GRAPH-1 is written.
  - DONE → ACCUM on `start_iteration`.
- Reset values:
  - state IDLE; all accumulators 0.
  - every `page_rank_new[k] = INIT_RANK`.
  - `update_valid`, `update_node_id`, `update_value`, `iteration_done`, `max_delta`, `id_error` all 0.
- ACCUM: for each `contrib_valid` with id < N, `acc[id] += contrib_value`, saturating at 2^64-1.
  - Back-to-back contributions to the same id must sum correctly; there are no lost updates.
  - An id ≥ N is dropped and sets `id_error`.
- A contribution in the same cycle as `scatter_complete` is accumulated before APPLY begins.
- `contrib_valid` outside ACCUM is ignored. It does not set `id_error`.
- APPLY, with counter k = 0..N-1 and one node per cycle:
  - `prod = acc[k]*DAMPING` (80-bit).
  - `new = BASE_TERM + (prod>>16)`, saturating to 64 bits.
  - Write `page_rank_new[k] = new`; pulse `update_valid` with k and new.
  - `running_max = max(running_max, |new - old page_rank_new[k]|)`.
- On entering DONE: `max_delta` ← running max.
- `start_iteration` in DONE:
  - clears all accumulators, the running max and k;
  - `max_delta` keeps its value until the next DONE.
- `start_iteration` in any other state is ignored.
- `scatter_complete` outside ACCUM is ignored.
- Reset mid-operation: immediate return to reset values, including `page_rank_new` = INIT_RANK.

## Timing
- Accumulation: a contribution sampled at edge t is reflected in `acc` after edge t.
- APPLY starts the cycle after `scatter_complete` is sampled.
- `update_valid` is high for exactly N consecutive cycles with k ascending, each written value registered.
- `iteration_done` rises the cycle after the last `update_valid`; latency from `scatter_complete` is N+1 cycles.
- `gather_enable` low freezes everything, including mid-APPLY; k resumes where it stopped.
- `start_iteration` and `scatter_complete` are sampled only when `gather_enable` is high.
- The rank vector is stable outside APPLY. During APPLY, entries ≥ k still hold old values.

## Test plan
All scenarios use N=4, FRAC_BITS=32 (INIT_RANK=0x4000_0000, BASE_TERM=0x0999_8000).
1. Reset, then read outputs → all `page_rank_new` = 0x4000_0000; all other outputs 0; state IDLE.
2. Enable; send node1 +0x1_0000_0000 twice, back-to-back; assert `scatter_complete` → `update_valid` for 4 cycles:
   - node1 = 0x1_BCCD_8000;
   - nodes 0, 2, 3 = 0x0999_8000;
   - `iteration_done` the next cycle; `max_delta` = 0x1_7CCD_8000.
3. Contribution with id 7 during ACCUM → dropped, `id_error` = 1 (sticky); other accumulators unchanged.
4. Contribution in the same cycle as `scatter_complete` (node2 +0x1_0000_0000) → node2 = 0x0999_8000 + 0xD99A_0000 = 0xE333_8000.
5. Deassert `gather_enable` for 3 cycles after the 2nd `update_valid` → strobes pause, then resume at k=2; 4 total strobes.
6. DONE + `start_iteration`, no contributions, then `scatter_complete` → all nodes = 0x0999_8000; `max_delta` reflects the drop from the previous values. Assert reset_n mid-APPLY → INIT values restored immediately.
